// File: rtl/egg_timer_pkg.sv
// Shared definitions for the egg countdown timer.
// Holds the controller state encodings, the BCD digit limits, the default
// alarm duration and a small digit-clamping helper used when loading.
package egg_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_ALARM = 3'd4
    } ctrl_state_t;

    localparam logic [3:0] BCD_ONES_MAX = 4'd9;
    localparam logic [3:0] BCD_TENS_MAX = 4'd5;

    localparam int ALARM_SECS_DEFAULT = 10;

    // Out-of-range set digits saturate to the digit's maximum.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
        return (d > max) ? max : d;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with a programmable maximum.
// Ports:
//   clk, reset   - clock and asynchronous active-high reset
//   clr          - synchronous zero (highest priority)
//   load         - load load_value, saturated to MAX
//   load_value   - value to load
//   dec_en       - decrement by one this cycle
//   value        - current digit value
//   borrow       - high when a decrement wraps this digit from 0 to MAX
module bcd_digit_down
    import egg_timer_pkg::*;
#(
    parameter logic [3:0] MAX = BCD_ONES_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       dec_en,
    output logic [3:0] value,
    output logic       borrow
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= 4'd0;
        end else if (clr) begin
            value <= 4'd0;
        end else if (load) begin
            value <= clamp_digit(load_value, MAX);
        end else if (dec_en) begin
            value <= (value == 4'd0) ? MAX : value - 4'd1;
        end
    end

    // The next-more-significant digit decrements only when this one wraps.
    assign borrow = dec_en && (value == 4'd0);

endmodule

// File: rtl/egg_countdown_ctrl.sv
// Egg timer countdown controller: MM:SS BCD countdown with pause, clear and
// a timed alarm phase.
// Ports:
//   clk, reset                 - clock and asynchronous active-high reset
//   tick_1hz                   - one-cycle 1 Hz enable
//   start, pause, clear        - debounced one-cycle button pulses
//   set_min_tens..set_sec_ones - BCD set time
//   min_tens..sec_ones         - BCD remaining time
//   running, paused, alarm     - state-decoded status outputs
//   ctrl_state                 - raw state encoding for debug
module egg_countdown_ctrl
    import egg_timer_pkg::*;
#(
    parameter int ALARM_SECS = ALARM_SECS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic [3:0] set_min_tens,
    input  logic [3:0] set_min_ones,
    input  logic [3:0] set_sec_tens,
    input  logic [3:0] set_sec_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       paused,
    output logic       alarm,
    output logic [2:0] ctrl_state
);

    localparam logic [7:0] ALARM_LAST = 8'(ALARM_SECS - 1);

    ctrl_state_t state, state_next;
    logic [7:0]  alarm_cnt;
    logic        count_clr, load_en, dec_en, at_one, set_nonzero;
    logic        borrow_so, borrow_st, borrow_mo, borrow_mt;

    assign set_nonzero = |{set_min_tens, set_min_ones, set_sec_tens, set_sec_ones};
    assign at_one      = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0001);

    assign count_clr = clear && (state == ST_LOAD || state == ST_RUN || state == ST_PAUSE);
    assign load_en   = (state == ST_LOAD);
    assign dec_en    = (state == ST_RUN) && tick_1hz && !clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A tick that reaches 00:00 wins over a simultaneous pause: the count is
    // already exhausted, so the alarm is the more useful outcome.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (!clear && start && set_nonzero) state_next = ST_LOAD;
            ST_LOAD:  state_next = clear ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                if (clear)                  state_next = ST_IDLE;
                else if (tick_1hz && at_one) state_next = ST_ALARM;
                else if (pause)             state_next = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (clear)      state_next = ST_IDLE;
                else if (start) state_next = ST_RUN;
            end
            ST_ALARM: begin
                if (clear || start)                        state_next = ST_IDLE;
                else if (tick_1hz && alarm_cnt == ALARM_LAST) state_next = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Counts alarm ticks; held at zero whenever the alarm is not sounding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_cnt <= 8'd0;
        end else if (state != ST_ALARM) begin
            alarm_cnt <= 8'd0;
        end else if (tick_1hz) begin
            alarm_cnt <= alarm_cnt + 8'd1;
        end
    end

    bcd_digit_down #(.MAX(BCD_ONES_MAX)) u_sec_ones (
        .clk(clk), .reset(reset), .clr(count_clr), .load(load_en),
        .load_value(set_sec_ones), .dec_en(dec_en),
        .value(sec_ones), .borrow(borrow_so)
    );

    bcd_digit_down #(.MAX(BCD_TENS_MAX)) u_sec_tens (
        .clk(clk), .reset(reset), .clr(count_clr), .load(load_en),
        .load_value(set_sec_tens), .dec_en(borrow_so),
        .value(sec_tens), .borrow(borrow_st)
    );

    bcd_digit_down #(.MAX(BCD_ONES_MAX)) u_min_ones (
        .clk(clk), .reset(reset), .clr(count_clr), .load(load_en),
        .load_value(set_min_ones), .dec_en(borrow_st),
        .value(min_ones), .borrow(borrow_mo)
    );

    // The top digit's borrow never occurs: the count stops at 00:00.
    bcd_digit_down #(.MAX(BCD_TENS_MAX)) u_min_tens (
        .clk(clk), .reset(reset), .clr(count_clr), .load(load_en),
        .load_value(set_min_tens), .dec_en(borrow_mo),
        .value(min_tens), .borrow(borrow_mt)
    );

    logic unused_borrow;
    assign unused_borrow = borrow_mt;

    assign running    = (state == ST_RUN);
    assign paused     = (state == ST_PAUSE);
    assign alarm      = (state == ST_ALARM);
    assign ctrl_state = state;

endmodule

// File: doc/egg_countdown_ctrl.md
EGG_COUNTDOWN_CTRL -- requirements
Module: egg_countdown_ctrl

Interface
REQ-001 Parameter: ALARM_SECS, default 10, number of 1 Hz ticks the alarm stays asserted (range 1..255).
REQ-002 Port: clk  in  1  system clock; every register SHALL be clocked on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: tick_1hz  in  1  single-cycle 1 Hz enable, synchronous to clk.
REQ-005 Port: start  in  1  debounced single-cycle pulse: start, resume or alarm acknowledge.
REQ-006 Port: pause  in  1  debounced single-cycle pulse: pause a running countdown.
REQ-007 Port: clear  in  1  debounced single-cycle pulse: abort to IDLE.
REQ-008 Port: set_min_tens, set_min_ones, set_sec_tens, set_sec_ones  in  4 each  BCD set time from the time-setting logic.
REQ-009 Port: min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD remaining time for the display.
REQ-010 Port: running  out  1  high in RUN.
REQ-011 Port: paused  out  1  high in PAUSE.
REQ-012 Port: alarm  out  1  buzzer enable, high in ALARM.
REQ-013 Port: ctrl_state  out  3  current state encoding, for debug.

Function
REQ-014 The states SHALL be IDLE, LOAD, RUN, PAUSE and ALARM.
REQ-015 In IDLE, a start with a nonzero set time SHALL go to LOAD; a start with a set time of 00:00 SHALL be ignored.
REQ-016 LOAD SHALL last one cycle, copy the set digits into the count registers, then go to RUN.
REQ-017 When loading, a ones digit >9 SHALL load as 9 and a tens digit >5 SHALL load as 5.
REQ-018 In RUN, each tick_1hz SHALL decrement the MM:SS count by one second in BCD:
  - a sec_ones borrow from 0 SHALL give 9;
  - a sec_tens borrow from 0 SHALL give 5;
  - min_ones wraps 0 to 9; min_tens wraps 0 to 5.
REQ-019 The tick that takes the count from 00:01 to 00:00 SHALL move the state to ALARM on the same edge.
REQ-020 A pause in RUN SHALL go to PAUSE. If tick_1hz occurs in the same cycle, the decrement SHALL still be applied.
REQ-021 In PAUSE the count SHALL hold and ticks SHALL be ignored; a start SHALL return to RUN.
REQ-022 In ALARM, an internal tick counter (width 8) SHALL count ALARM_SECS ticks, then the state SHALL go to IDLE.
REQ-023 A start or clear in ALARM SHALL go to IDLE on the next edge.
REQ-024 A clear in LOAD, RUN or PAUSE SHALL go to IDLE and zero the count registers.
REQ-025 Clear SHALL have priority over start, pause and tick in the same cycle.
REQ-026 Start in RUN, pause outside RUN, and start in LOAD SHALL be ignored.
REQ-027 In IDLE the count registers SHALL hold their last value (00:00 after alarm or clear); they are not updated until the next LOAD.
REQ-028 All outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from any input to any output.

Reset
REQ-029 Reset SHALL force: state IDLE; all count digits 0; alarm tick counter 0; running, paused and alarm 0.
REQ-030 Reset asserted mid-RUN or mid-ALARM SHALL take effect immediately, without waiting for a clock edge.
REQ-031 After reset deassertion, the first start SHALL be handled per REQ-015.

Structure
REQ-032 The shared package egg_timer_pkg SHALL hold the state encodings (IDLE=0, LOAD=1, RUN=2, PAUSE=3, ALARM=4), the BCD limits (9, 5) and the ALARM_SECS default.
REQ-033 A single sub-module, bcd_digit_down (one BCD digit with programmable max, decrement-enable input and borrow output), SHALL be instantiated four times, chained by borrow.

Verification
REQ-034 Set 00:03, start, 3 ticks -> count 00:02, 00:01, 00:00; alarm rises on the third tick; running falls on the same edge.
REQ-035 Set 10:00, start, 1 tick -> 09:59; set 01:00, 1 tick -> 00:59 (multi-digit borrow).
REQ-036 Set 00:05, start, 2 ticks, pause with a simultaneous tick -> 00:02 and paused=1; 3 further ticks -> still 00:02; start plus 2 ticks -> 00:00 and alarm=1.
REQ-037 With ALARM_SECS=3: alarm stays high for exactly 3 ticks, then IDLE. In a second run, start during alarm -> IDLE next edge with alarm=0.
REQ-038 Set 00:00 and start -> stays IDLE. Set digits sec_ones=12, sec_tens=7 -> load 00:59. Clear and tick in the same cycle in RUN -> IDLE with count 00:00.
REQ-039 Reset asserted between clock edges during RUN at 05:30 -> all outputs 0 and IDLE immediately; a following start reloads the set time.
